regbank_dump: RTL

//  Reads the nRisc 4x8 register bank through one combinational read port and streams it out.
//  On a start request it walks registers 0..NREGS-1 and emits one byte per register, then a

---
 rtl/nrisc_pkg.sv | 13 +
 rtl/regbank_dump.sv | 81 ++++++++
 2 files changed

// File: rtl/nrisc_pkg.sv
// nrisc_pkg: register bank geometry and dump FSM state encoding
package nrisc_pkg;
  localparam int DEF_NREGS  = 4;
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 8;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_SEND = 3'd2,
    S_CSUM = 3'd3,
    S_FIN  = 3'd4
  } state_t;
endpackage

// File: rtl/regbank_dump.sv
// regbank_dump: walks the register bank and streams each byte plus an XOR checksum
module regbank_dump
  import nrisc_pkg::*;
#(
  parameter int NREGS  = DEF_NREGS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic hs;
  assign out_valid = (state_q == S_SEND) || (state_q == S_CSUM);
  assign out_last  = state_q == S_CSUM;
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_FIN;
  assign rd_addr   = idx_q;
  assign out_data  = data_q;
  assign hs        = out_valid && out_ready;
  // next-state, index, stream byte and checksum; abort overrides any handshake
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    csum_d  = csum_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_READ;
        idx_d   = '0;
        csum_d  = '0;
      end
      S_READ: begin
        data_d  = rd_data;
        csum_d  = csum_q ^ rd_data;
        state_d = S_SEND;
      end
      S_SEND: if (hs) begin
        state_d = (idx_q == LAST_IDX) ? S_CSUM : S_READ;
        idx_d   = (idx_q == LAST_IDX) ? idx_q : idx_q + 1'b1;
        data_d  = (idx_q == LAST_IDX) ? csum_q : data_q;
      end
      S_CSUM: state_d = hs ? S_FIN : S_CSUM;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      idx_d   = '0;
      csum_d  = '0;
    end
  end
  // state registers with immediate clear on reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      csum_q  <= csum_d;
    end
  end
endmodule
